// File: rtl/contador_pkg.sv
// Shared types and defaults for the modulus-N up/down counter family.
package contador_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP   = 2'd0,
    MODE_SAT    = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_RSVD   = 2'd3
  } cnt_mode_t;

  localparam int NBITS_COUNT_DEFAULT = 8;

endpackage

// File: rtl/contador_step.sv
// Combinational next-count computation for one enabled step, including the
// boundary handling of each mode. The caller supplies the effective direction.
module contador_step
  import contador_pkg::*;
#(
  parameter int NBITS = NBITS_COUNT_DEFAULT
) (
  input  logic [NBITS-1:0] count_i,
  input  logic [NBITS-1:0] modulus_i,
  input  cnt_mode_t        mode_i,
  input  logic             dir_i,
  output logic [NBITS-1:0] count_o,
  output logic             dir_o,
  output logic             event_o,
  output logic             up_event_o,
  output logic             down_event_o
);

  logic mod_zero;
  assign mod_zero = (modulus_i == '0);

  always_comb begin
    count_o      = count_i;
    dir_o        = dir_i;
    up_event_o   = 1'b0;
    down_event_o = 1'b0;
    if (dir_i) begin
      if (count_i < modulus_i) begin
        count_o = count_i + 1'b1;
      end else begin
        up_event_o = 1'b1;
        case (mode_i)
          MODE_SAT:    count_o = modulus_i;
          MODE_BOUNCE: begin
            count_o = mod_zero ? '0 : modulus_i - 1'b1;
            dir_o   = 1'b0;
          end
          default:     count_o = '0;
        endcase
      end
    end else begin
      // A count left above a freshly lowered modulus is pulled back silently.
      if (count_i > modulus_i) begin
        count_o = modulus_i;
      end else if (count_i != '0) begin
        count_o = count_i - 1'b1;
      end else begin
        down_event_o = 1'b1;
        case (mode_i)
          MODE_SAT:    count_o = '0;
          MODE_BOUNCE: begin
            count_o = mod_zero ? '0 : {{(NBITS-1){1'b0}}, 1'b1};
            dir_o   = 1'b1;
          end
          default:     count_o = modulus_i;
        endcase
      end
    end
  end

  assign event_o = up_event_o | down_event_o;

endmodule

// File: rtl/contador_modn_updown.sv
// Loadable up/down counter with programmable modulus, wrap/saturate/bounce
// boundary modes, registered terminal-count pulse and sticky boundary flags.
module contador_modn_updown
  import contador_pkg::*;
#(
  parameter int                     NBITS_COUNT = NBITS_COUNT_DEFAULT,
  parameter logic [NBITS_COUNT-1:0] RESET_VALUE = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [NBITS_COUNT-1:0] Data_in,
  input  logic                   counter_on,
  input  logic                   count_up,
  input  logic [1:0]             mode,
  input  logic [NBITS_COUNT-1:0] Modulus,
  input  logic                   clear_flags,
  output logic [NBITS_COUNT-1:0] Count,
  output logic                   dir_o,
  output logic                   tc,
  output logic                   overflow_flag,
  output logic                   underflow_flag
);

  logic [NBITS_COUNT-1:0] count_q, count_d, step_count;
  logic                   dir_q, dir_d, step_dir;
  logic                   tc_q, tc_d;
  logic                   ovf_q, ovf_d, unf_q, unf_d;
  logic                   dir_eff, step_event, step_up_event, step_down_event;
  cnt_mode_t              mode_e;

  assign mode_e  = cnt_mode_t'(mode);
  assign dir_eff = (mode_e == MODE_BOUNCE) ? dir_q : count_up;

  contador_step #(
    .NBITS (NBITS_COUNT)
  ) u_step (
    .count_i      (count_q),
    .modulus_i    (Modulus),
    .mode_i       (mode_e),
    .dir_i        (dir_eff),
    .count_o      (step_count),
    .dir_o        (step_dir),
    .event_o      (step_event),
    .up_event_o   (step_up_event),
    .down_event_o (step_down_event)
  );

  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    tc_d    = 1'b0;
    ovf_d   = clear_flags ? 1'b0 : ovf_q;
    unf_d   = clear_flags ? 1'b0 : unf_q;
    if (load) begin
      count_d = (Data_in > Modulus) ? Modulus : Data_in;
      dir_d   = count_up;
    end else if (counter_on) begin
      count_d = step_count;
      dir_d   = step_dir;
      tc_d    = step_event;
      // A boundary event outranks a simultaneous clear.
      if (step_up_event)   ovf_d = 1'b1;
      if (step_down_event) unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= RESET_VALUE;
      dir_q   <= 1'b1;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      dir_q   <= dir_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign Count          = count_q;
  assign dir_o          = dir_q;
  assign tc             = tc_q;
  assign overflow_flag  = ovf_q;
  assign underflow_flag = unf_q;

endmodule

// File: tb/tb_contador_modn_updown.sv
// Directed-vector bench for contador_modn_updown (NBITS_COUNT=4, RESET_VALUE=0).
module tb_contador_modn_updown;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [3:0] Data_in;
  logic       counter_on;
  logic       count_up;
  logic [1:0] mode;
  logic [3:0] Modulus;
  logic       clear_flags;
  logic [3:0] Count;
  logic       dir_o;
  logic       tc;
  logic       overflow_flag;
  logic       underflow_flag;

  int checks = 0;
  int errors = 0;

  contador_modn_updown #(
    .NBITS_COUNT (4),
    .RESET_VALUE (4'd0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .load           (load),
    .Data_in        (Data_in),
    .counter_on     (counter_on),
    .count_up       (count_up),
    .mode           (mode),
    .Modulus        (Modulus),
    .clear_flags    (clear_flags),
    .Count          (Count),
    .dir_o          (dir_o),
    .tc             (tc),
    .overflow_flag  (overflow_flag),
    .underflow_flag (underflow_flag)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply one cycle of control inputs, then sample 1 time unit after the edge.
  task automatic cycle(input logic ld, input logic on, input logic up,
                       input logic [3:0] din, input logic clr);
    load        = ld;
    counter_on  = on;
    count_up    = up;
    Data_in     = din;
    clear_flags = clr;
    @(posedge clk);
    #1;
    $display("t=%0t mode=%0d mod=%0d ld=%0b on=%0b up=%0b din=%0d clr=%0b -> Count=%0d dir=%0b tc=%0b ovf=%0b unf=%0b",
             $time, mode, Modulus, ld, on, up, din, clr, Count, dir_o, tc,
             overflow_flag, underflow_flag);
  endtask

  task automatic expect_state(input string tag, input int c, input int d, input int t);
    check_value({tag, ".count"}, Count, c);
    check_value({tag, ".dir"}, dir_o, d);
    check_value({tag, ".tc"}, tc, t);
  endtask

  initial begin
    reset = 1'b1; load = 0; counter_on = 0; count_up = 1; Data_in = 0;
    clear_flags = 0; mode = 2'd0; Modulus = 4'd9;
    repeat (2) @(posedge clk);
    #1;
    check_value("rst.count", Count, 0);
    check_value("rst.dir", dir_o, 1);
    check_value("rst.tc", tc, 0);
    check_value("rst.ovf", overflow_flag, 0);
    check_value("rst.unf", underflow_flag, 0);
    reset = 1'b0;

    // 1: asynchronous reset mid-cycle
    for (int i = 1; i <= 5; i++) cycle(0, 1, 1, 0, 0);
    check_value("t1.count5", Count, 5);
    #2 reset = 1'b1;
    #1;
    check_value("t1.async.count", Count, 0);
    check_value("t1.async.dir", dir_o, 1);
    check_value("t1.async.ovf", overflow_flag, 0);
    check_value("t1.async.unf", underflow_flag, 0);
    #1 reset = 1'b0;
    cycle(0, 1, 1, 0, 0); expect_state("t1.s1", 1, 1, 0);
    cycle(0, 1, 1, 0, 0); expect_state("t1.s2", 2, 1, 0);

    // 2: WRAP up through the modulus
    cycle(1, 0, 1, 8, 0); expect_state("t2.load", 8, 1, 0);
    cycle(0, 1, 1, 0, 0); expect_state("t2.s1", 9, 1, 0);
    cycle(0, 1, 1, 0, 0); expect_state("t2.s2", 0, 1, 1);
    cycle(0, 1, 1, 0, 0); expect_state("t2.s3", 1, 1, 0);
    check_value("t2.ovf", overflow_flag, 1);
    check_value("t2.unf", underflow_flag, 0);

    // 3: SAT down into zero
    mode = 2'd1;
    cycle(1, 0, 0, 1, 0); expect_state("t3.load", 1, 0, 0);
    cycle(0, 1, 0, 0, 0); expect_state("t3.s1", 0, 0, 0);
    cycle(0, 1, 0, 0, 0); expect_state("t3.s2", 0, 0, 1);
    cycle(0, 1, 0, 0, 0); expect_state("t3.s3", 0, 0, 1);
    check_value("t3.unf", underflow_flag, 1);
    cycle(0, 1, 1, 0, 0); expect_state("t3.up", 1, 1, 0);

    // 6a: clear with no event
    cycle(0, 0, 1, 0, 1);
    check_value("t6.clr.ovf", overflow_flag, 0);
    check_value("t6.clr.unf", underflow_flag, 0);
    check_value("t6.clr.tc", tc, 0);

    // 4: BOUNCE triangle, count_up ignored while stepping
    mode = 2'd2; Modulus = 4'd3;
    cycle(1, 0, 1, 0, 0); expect_state("t4.load", 0, 1, 0);
    cycle(0, 1, 0, 0, 0); expect_state("t4.s1", 1, 1, 0);
    cycle(0, 1, 0, 0, 0); expect_state("t4.s2", 2, 1, 0);
    cycle(0, 1, 0, 0, 0); expect_state("t4.s3", 3, 1, 0);
    cycle(0, 1, 0, 0, 0); expect_state("t4.s4", 2, 0, 1);
    check_value("t4.ovf.mid", overflow_flag, 1);
    check_value("t4.unf.mid", underflow_flag, 0);
    cycle(0, 1, 1, 0, 0); expect_state("t4.s5", 1, 0, 0);
    cycle(0, 1, 1, 0, 0); expect_state("t4.s6", 0, 0, 0);
    cycle(0, 1, 1, 0, 0); expect_state("t4.s7", 1, 1, 1);
    check_value("t4.ovf", overflow_flag, 1);
    check_value("t4.unf", underflow_flag, 1);

    // 5: load clamp, load priority, runtime modulus lowering
    mode = 2'd0; Modulus = 4'd9;
    cycle(1, 0, 1, 15, 0); expect_state("t5.clamp", 9, 1, 0);
    cycle(1, 1, 1, 4, 0);  expect_state("t5.prio", 4, 1, 0);
    Modulus = 4'd2;
    cycle(0, 1, 0, 0, 0);  expect_state("t5.lower", 2, 0, 0);
    check_value("t5.unf", underflow_flag, 1);

    // 6b: clear versus simultaneous event
    Modulus = 4'd9;
    cycle(0, 0, 1, 0, 1);
    check_value("t6.clr2.ovf", overflow_flag, 0);
    cycle(1, 0, 1, 9, 0);  expect_state("t6.load", 9, 1, 0);
    cycle(0, 1, 1, 0, 1);  expect_state("t6.evt", 0, 1, 1);
    check_value("t6.evt.ovf", overflow_flag, 1);
    check_value("t6.evt.unf", underflow_flag, 0);

    // Modulus=0 in BOUNCE: every step an event, direction toggles
    mode = 2'd2; Modulus = 4'd0;
    cycle(0, 1, 1, 0, 1);  expect_state("m0.s1", 0, 0, 1);
    cycle(0, 1, 1, 0, 0);  expect_state("m0.s2", 0, 1, 1);
    check_value("m0.unf", underflow_flag, 1);
    cycle(0, 0, 1, 0, 0);  expect_state("m0.hold", 0, 1, 0);

    // Reserved mode behaves as WRAP, both directions
    mode = 2'd3; Modulus = 4'd9;
    cycle(1, 0, 1, 9, 0);  expect_state("rsvd.load", 9, 1, 0);
    cycle(0, 1, 1, 0, 0);  expect_state("rsvd.up", 0, 1, 1);
    cycle(0, 1, 0, 0, 0);  expect_state("rsvd.dn", 9, 0, 1);

    // Full-range modulus wraps 15 -> 0
    mode = 2'd0; Modulus = 4'd15;
    cycle(1, 0, 1, 15, 0); expect_state("full.load", 15, 1, 0);
    cycle(0, 1, 1, 0, 0);  expect_state("full.wrap", 0, 1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
